// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate path.
// The default widths describe the 12x12 multiplier feeding a 32-bit accumulator.
package mac_pkg;

  localparam int unsigned DEF_IN_W   = 12;
  localparam int unsigned DEF_PROD_W = 2 * DEF_IN_W;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_BURST  = 8;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } mac_state_e;

  // Counter width that can still represent the value BURST itself.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered unsigned multiply with a valid bit.
// The product register holds its value when no beat is accepted; only the valid bit drops.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned PROD_W = 2 * IN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic [PROD_W-1:0] p,
  output logic              p_valid
);

  logic [PROD_W-1:0] p_d, p_q;
  logic              p_valid_d, p_valid_q;

  always_comb begin
    p_d       = p_q;
    p_valid_d = 1'b0;
    if (beat && !clear) begin
      p_d       = PROD_W'(a) * PROD_W'(b);
      p_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p       = p_q;
  assign p_valid = p_valid_q;

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates BURST products from the multiply stage and hands the sum out
// over valid/ready with a sticky carry-out flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned PROD_W = 2 * IN_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned BURST  = DEF_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = cnt_width(BURST);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if (PROD_W != 2 * IN_W) begin : g_bad_prod_w
    $error("mac_accumulator: PROD_W must equal 2*IN_W");
  end
  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mac_accumulator: ACC_W must be >= PROD_W");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("mac_accumulator: BURST must be >= 1");
  end

  mac_state_e        state_d, state_q;
  logic              out_valid_d, out_valid_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic              ovf_d, ovf_q;
  logic [CNT_W-1:0]  cnt_in_d, cnt_in_q;
  logic [CNT_W-1:0]  cnt_acc_d, cnt_acc_q;
  logic [SUM_W-1:0]  sum_ext;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              beat;
  logic              handshake;

  // Ready is forced low while reset is held so no beat is promised during reset.
  assign in_ready  = rst_n && (state_q == ST_ACC) && (cnt_in_q < BURST_C) && !clear;
  assign beat      = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  mac_mult_stage #(
    .IN_W  (IN_W),
    .PROD_W(PROD_W)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .beat   (beat),
    .a      (in_a),
    .b      (in_b),
    .p      (prod),
    .p_valid(prod_valid)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_in_d    = cnt_in_q;
    cnt_acc_d   = cnt_acc_q;
    sum_ext     = {1'b0, acc_q} + SUM_W'(prod);

    if (clear) begin
      state_d     = ST_ACC;
      out_valid_d = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      cnt_in_d    = '0;
      cnt_acc_d   = '0;
    end else begin
      if (beat) begin
        cnt_in_d = cnt_in_q + ONE_C;
      end
      case (state_q)
        ST_ACC: begin
          out_valid_d = 1'b0;
          if (prod_valid) begin
            acc_d     = sum_ext[ACC_W-1:0];
            ovf_d     = ovf_q | sum_ext[ACC_W];
            cnt_acc_d = cnt_acc_q + ONE_C;
            if (cnt_acc_q == BURST_C - ONE_C) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // out_valid trails the state by one edge, giving the two-edge result latency.
          out_valid_d = 1'b1;
          if (handshake) begin
            state_d     = ST_ACC;
            out_valid_d = 1'b0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_in_d    = '0;
            cnt_acc_d   = '0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_in_q    <= '0;
      cnt_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_in_q    <= cnt_in_d;
      cnt_acc_q   <= cnt_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized-bubble checks for mac_accumulator; a 24-bit accumulator
// instance shares the stimulus so wrap-around and the sticky carry can be observed.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_a = '0;
  logic [11:0] in_b = '0;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_sum;
  logic        in_ready24, out_valid24, out_ovf24;
  logic [23:0] out_sum24;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.IN_W(12), .PROD_W(24), .ACC_W(32), .BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  mac_accumulator #(.IN_W(12), .PROD_W(24), .ACC_W(24), .BURST(8)) dut24 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready24), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid24), .out_ready(out_ready), .out_sum(out_sum24), .out_ovf(out_ovf24)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [11:0] a, input logic [11:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beat_accept: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int waited = 0;
    while (!out_valid && waited < 60) begin
      step();
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL result_timeout: out_valid=%0b, required 1 within 60 cycles", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b need 0", out_valid); end
    if (out_sum !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_sum: got %0h need 0", out_sum); end
    if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf: got %0b need 0", out_ovf); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b need 0", in_ready); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) send_beat(12'd5, 12'd5);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_sum !== 32'd0) begin errors++; $display("[TB] FAIL midreset_out_sum: got %0h need 0", out_sum); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_in_ready: got %0b need 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %0b need 0", out_valid); end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %0b need 1", in_ready); end
    for (int i = 0; i < 8; i++) send_beat(12'd1, 12'd1);
    wait_result();
    checks += 2;
    if (out_sum !== 32'd8) begin errors++; $display("[TB] FAIL post_reset_sum: got %0d need 8", out_sum); end
    if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ovf: got %0b need 0", out_ovf); end
    handshake();
  endtask

  task automatic test_burst_no_gaps();
    for (int i = 1; i <= 8; i++) send_beat(12'(i), 12'(i));
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge0: out_valid=%0b need 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge1: out_valid=%0b need 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_edge2: out_valid=%0b need 1", out_valid); end
    wait_result();
    checks += 2;
    if (out_sum !== 32'd204) begin errors++; $display("[TB] FAIL squares_sum: got %0d need 204", out_sum); end
    if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL squares_ovf: got %0b need 0", out_ovf); end
    handshake();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) send_beat(12'hFFF, 12'hFFF);
    wait_result();
    checks += 4;
    if (out_sum !== 32'h07FF_0008) begin errors++; $display("[TB] FAIL max_sum32: got %0h need 7ff0008", out_sum); end
    if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL max_ovf32: got %0b need 0", out_ovf); end
    if (out_sum24 !== 24'hFF_0008) begin errors++; $display("[TB] FAIL max_sum24: got %0h need ff0008", out_sum24); end
    if (out_ovf24 !== 1'b1) begin errors++; $display("[TB] FAIL max_ovf24: got %0b need 1", out_ovf24); end
    handshake();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) send_beat(12'd2, 12'd2);
    wait_result();
    in_valid = 1'b1;
    in_a = 12'd9;
    in_b = 12'd9;
    for (int c = 0; c < 5; c++) begin
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: cycle %0d got %0b need 1", c, out_valid); end
      if (out_sum !== 32'd32) begin errors++; $display("[TB] FAIL hold_sum: cycle %0d got %0d need 32", c, out_sum); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: cycle %0d got %0b need 0", c, in_ready); end
    end
    in_valid = 1'b0;
    handshake();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL after_hs_valid: got %0b need 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL after_hs_in_ready: got %0b need 1", in_ready); end
    for (int i = 0; i < 8; i++) send_beat(12'd1, 12'd3);
    wait_result();
    checks++;
    if (out_sum !== 32'd24) begin errors++; $display("[TB] FAIL restart_sum: got %0d need 24", out_sum); end
    handshake();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) send_beat(12'd7, 12'd7);
    in_valid = 1'b1;
    in_a = 12'd7;
    in_b = 12'd7;
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_in_ready: got %0b need 0", in_ready); end
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_no_output: cycle %0d got %0b need 0", c, out_valid); end
    end
    for (int i = 0; i < 8; i++) send_beat(12'd2, 12'd3);
    wait_result();
    checks += 2;
    if (out_sum !== 32'd48) begin errors++; $display("[TB] FAIL post_clear_sum: got %0d need 48", out_sum); end
    if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL post_clear_ovf: got %0b need 0", out_ovf); end
    handshake();
  endtask

  task automatic test_bubbles();
    logic [11:0] a, b;
    logic [23:0] p;
    logic [32:0] m32;
    logic [24:0] m24;
    logic        o32, o24;
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send_beat(12'(i), 12'(i));
    end
    wait_result();
    checks++;
    if (out_sum !== 32'd204) begin errors++; $display("[TB] FAIL bubble_squares_sum: got %0d need 204", out_sum); end
    handshake();
    for (int n = 0; n < 1000; n++) begin
      m32 = '0;
      m24 = '0;
      o32 = 1'b0;
      o24 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        a = 12'($urandom);
        b = 12'($urandom);
        p = 24'(a) * 24'(b);
        m32 = {1'b0, m32[31:0]} + 33'(p);
        o32 = o32 | m32[32];
        m24 = {1'b0, m24[23:0]} + 25'(p);
        o24 = o24 | m24[24];
        repeat ($urandom_range(0, 2)) step();
        send_beat(a, b);
      end
      wait_result();
      repeat ($urandom_range(0, 2)) step();
      checks += 4;
      if (out_sum !== m32[31:0]) begin errors++; $display("[TB] FAIL rand_sum32: burst %0d got %0h need %0h", n, out_sum, m32[31:0]); end
      if (out_ovf !== o32) begin errors++; $display("[TB] FAIL rand_ovf32: burst %0d got %0b need %0b", n, out_ovf, o32); end
      if (out_sum24 !== m24[23:0]) begin errors++; $display("[TB] FAIL rand_sum24: burst %0d got %0h need %0h", n, out_sum24, m24[23:0]); end
      if (out_ovf24 !== o24) begin errors++; $display("[TB] FAIL rand_ovf24: burst %0d got %0b need %0b", n, out_ovf24, o24); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_burst_no_gaps();
    test_wrap();
    test_backpressure();
    test_clear();
    test_bubbles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
